// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: stage/request indices and default masks.
package pipe_ctrl_pkg;

    localparam int ST_PC    = 0;
    localparam int ST_PREIF = 1;
    localparam int ST_IFID  = 2;
    localparam int ST_IDEX  = 3;
    localparam int ST_EXMEM = 4;
    localparam int ST_MEMWB = 5;

    localparam int RQ_COMPRESS  = 0;
    localparam int RQ_LOADUSE   = 1;
    localparam int RQ_MULDIV    = 2;
    localparam int RQ_JUMP      = 3;
    localparam int RQ_TRAPCSR   = 4;
    localparam int RQ_TRAPFLUSH = 5;
    localparam int RQ_IFRAM     = 6;
    localparam int RQ_MEMRAM    = 7;

    // Slice r of each mask sits at bits [r*6 +: 6]; concatenations list r7 first.
    localparam logic [47:0] DEF_STALL_MASK = {
        6'b011111, 6'b011111, 6'b000010, 6'b111111,
        6'b000010, 6'b000111, 6'b000111, 6'b000010
    };
    localparam logic [47:0] DEF_FLUSH_MASK = {
        6'b100000, 6'b000000, 6'b001110, 6'b001110,
        6'b001110, 6'b010000, 6'b001000, 6'b000010
    };
    localparam logic [7:0] DEF_DEFER_MASK = 8'b0010_1000;

endpackage

// File: rtl/hazard_prio_enc.sv
// Fixed-priority encoder: highest set request index wins, result is one-hot.
module hazard_prio_enc #(
    parameter int NREQ = 8
) (
    input  logic [NREQ-1:0] eff,
    output logic [NREQ-1:0] grant,
    output logic            valid
);

    always_comb begin
        grant = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (eff[r]) begin
                grant    = '0;
                grant[r] = 1'b1;
            end
        end
    end

    assign valid = |eff;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: arbitrates stall/flush requests, replays deferred flushes,
// and tracks stall duration (watchdog) and total stall cycles.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int                       NSTAGE     = 6,
    parameter int                       NREQ       = 8,
    parameter logic [NREQ*NSTAGE-1:0]   STALL_MASK = DEF_STALL_MASK,
    parameter logic [NREQ*NSTAGE-1:0]   FLUSH_MASK = DEF_FLUSH_MASK,
    parameter logic [NREQ-1:0]          DEFER_MASK = DEF_DEFER_MASK,
    parameter int                       WDT_W      = 16,
    parameter logic [WDT_W-1:0]         WDT_LIMIT  = 16'hFFFF,
    parameter int                       CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_i,
    input  logic              perf_clr_i,
    output logic [NREQ-1:0]   grant_o,
    output logic [NSTAGE-1:0] stall_o,
    output logic [NSTAGE-1:0] flush_o,
    output logic [NREQ-1:0]   pend_o,
    output logic              wdt_trip_o,
    output logic [CNT_W-1:0]  stall_cycles_o
);

    logic [NREQ-1:0]   pend;
    logic [NREQ-1:0]   eff;
    logic [NREQ-1:0]   win;
    logic              win_valid;
    logic [NSTAGE-1:0] stall_sel;
    logic [NSTAGE-1:0] flush_sel;
    logic [WDT_W-1:0]  wdt_cnt;
    logic [WDT_W-1:0]  wdt_nxt;

    assign eff = req_i | pend;

    hazard_prio_enc #(.NREQ(NREQ)) u_prio (
        .eff   (eff),
        .grant (win),
        .valid (win_valid)
    );

    // AND-OR mux over the one-hot winner; all-zero when nothing is requested.
    always_comb begin
        stall_sel = '0;
        flush_sel = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (win[r]) begin
                stall_sel = stall_sel | STALL_MASK[r*NSTAGE +: NSTAGE];
                flush_sel = flush_sel | FLUSH_MASK[r*NSTAGE +: NSTAGE];
            end
        end
    end

    // Reset forces a full flush with no stall so the pipe drains to bubbles.
    always_comb begin
        if (rst) begin
            grant_o = '0;
            stall_o = '0;
            flush_o = '1;
        end else begin
            grant_o = win_valid ? win : '0;
            stall_o = stall_sel;
            flush_o = flush_sel;
        end
    end

    always_comb begin
        wdt_nxt = '0;
        if (stall_o[0]) begin
            wdt_nxt = (wdt_cnt == WDT_LIMIT) ? wdt_cnt : wdt_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend           <= '0;
            wdt_cnt        <= '0;
            wdt_trip_o     <= 1'b0;
            stall_cycles_o <= '0;
        end else begin
            // A grant clears the bit even if the same request would set it again.
            pend    <= (pend & ~grant_o) | (DEFER_MASK & req_i & ~grant_o);
            wdt_cnt <= wdt_nxt;
            if (wdt_nxt == WDT_LIMIT) begin
                wdt_trip_o <= 1'b1;
            end
            if (perf_clr_i) begin
                stall_cycles_o <= '0;
            end else if (|stall_o) begin
                stall_cycles_o <= stall_cycles_o + 1'b1;
            end
        end
    end

    assign pend_o = pend;

endmodule
